// File: rtl/main_mem_pkg.sv
// Purpose: shared types and helpers for the backing-memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package main_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DONE = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_DONE = 3'd4,
        ST_RELEASE = 3'd5
    } mem_state_t;

    // Width of the word index for a storage of 'depth' words (at least 1 bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// Purpose: single-port word storage, synchronous write, combinational read.
// Latency: write lands on the clock edge with wr_en high; read is same-cycle.
// Backpressure: none; every enabled write is taken.
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_dat,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_dat
);

    // Contents are deliberately not reset: a reset must not wipe memory.
    logic [WORD_W-1:0] mem_q [DEPTH];

    // Commit one word per enabled edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/main_mem_ctrl.sv
// Purpose: fixed-latency backing memory serving cache fills and write-throughs.
// Latency: done pulse READ_LATENCY / WRITE_LATENCY cycles after the accept edge.
// Backpressure: one request at a time; busy high until back in IDLE, held requests not re-serviced.
module main_mem_ctrl
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       memAddr,
    input  logic [31:0]       memWriteData,
    output logic [31:0]       memReadData,
    output logic              MemReadReady,
    output logic              MemReadDone,
    output logic              MemWriteReady,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int CNT_W = 16;

    // Counter preloads: the wait state exits when the counter decrements to 0,
    // so loading LATENCY-1 puts the done pulse LATENCY cycles after accept.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    mem_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   wdat_q, wdat_d;
    logic [WORD_W-1:0]   rd_dat_q, rd_dat_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;

    logic [IDX_W-1:0]    addr_idx;
    logic [WORD_W-1:0]   arr_rd_dat;
    logic                mem_we;
    logic                unused_addr;

    // Upper address bits alias (modulo depth) and byte-offset bits are ignored.
    assign addr_idx    = memAddr[IDX_W+1:2];
    assign unused_addr = ^{memAddr[31:IDX_W+2], memAddr[1:0]};

    // Next-state, latency counter, request latching and statistics.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdat_d   = wdat_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Write has priority; a simultaneous read is dropped.
                if (MemWrite) begin
                    idx_d   = addr_idx;
                    wdat_d  = memWriteData;
                    cnt_d   = WR_LOAD;
                    state_d = (WRITE_LATENCY == 1) ? ST_WR_DONE : ST_WR_WAIT;
                end else if (MemRead) begin
                    idx_d   = addr_idx;
                    cnt_d   = RD_LOAD;
                    state_d = (READ_LATENCY == 1) ? ST_RD_DONE : ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RD_DONE: begin
                rd_cnt_d = rd_cnt_q + 16'd1;
                state_d  = ST_RELEASE;
            end

            ST_WR_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_WR_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_WR_DONE: begin
                // Commit happens on the edge closing this state, so a reset
                // arriving earlier leaves the target word untouched.
                mem_we   = 1'b1;
                wr_cnt_d = wr_cnt_q + 16'd1;
                state_d  = ST_RELEASE;
            end

            ST_RELEASE: begin
                // Wait for the requester to drop or move on, so a still-held
                // request is not serviced twice.
                if ((!MemRead && !MemWrite) || (addr_idx != idx_q)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is captured on entry to RD_DONE and then held until the next fill.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if ((state_d == ST_RD_DONE) && (state_q != ST_RD_DONE)) begin
            rd_dat_d = arr_rd_dat;
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdat_q   <= '0;
            rd_dat_q <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdat_q   <= wdat_d;
            rd_dat_q <= rd_dat_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Read port follows idx_d so that a one-cycle read latency still sees the
    // index being accepted this edge; write port uses the latched index.
    main_mem_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk    (clk),
        .wr_en  (mem_we),
        .wr_idx (idx_q),
        .wr_dat (wdat_q),
        .rd_idx (idx_d),
        .rd_dat (arr_rd_dat)
    );

    assign MemReadDone   = (state_q == ST_RD_DONE);
    assign MemReadReady  = (state_q == ST_RD_DONE);
    assign MemWriteReady = (state_q == ST_WR_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign memReadData   = rd_dat_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Purpose: directed self-checking bench for main_mem_ctrl.
// Latency: expects 4-cycle read/write latency (default parameters).
// Backpressure: exercises held requests, read/write collision and mid-write reset.
module tb_main_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        MemReadReady;
    logic        MemReadDone;
    logic        MemWriteReady;
    logic        busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_vec;
    int n_err;

    main_mem_ctrl #(
        .DEPTH_WORDS   (1024),
        .READ_LATENCY  (4),
        .WRITE_LATENCY (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .memAddr       (memAddr),
        .memWriteData  (memWriteData),
        .memReadData   (memReadData),
        .MemReadReady  (MemReadReady),
        .MemReadDone   (MemReadDone),
        .MemWriteReady (MemWriteReady),
        .busy          (busy),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for its done pulse, then drop the
    // request and let the controller return to IDLE.
    task automatic xact(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdat,
                        input logic [31:0] exp_rdat);
        int lat;
        bit seen;
        int stray;
        @(negedge clk);
        MemRead      = rd;
        MemWrite     = wr;
        memAddr      = addr;
        memWriteData = wdat;
        lat   = 0;
        seen  = 1'b0;
        stray = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (wr ? MemWriteReady : MemReadDone) seen = 1'b1;
            else if (MemReadDone || MemWriteReady) stray++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        if (wr) begin
            chk({tag, "_no_rd_pulse"}, 32'({stray[15:0], MemReadDone}), 32'd0);
        end else begin
            chk({tag, "_rdy"}, {31'd0, MemReadReady}, 32'd1);
            chk({tag, "_data"}, memReadData, exp_rdat);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        chk({tag, "_width"}, {30'd0, MemReadDone, MemWriteReady}, 32'd0);
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int extra;
        bit seen;

        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        memAddr      = 32'd0;
        memWriteData = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_rdone", {31'd0, MemReadDone}, 32'd0);
        chk("rst_rrdy",  {31'd0, MemReadReady}, 32'd0);
        chk("rst_wrdy",  {31'd0, MemWriteReady}, 32'd0);
        chk("rst_rdata", memReadData, 32'd0);
        chk("rst_rdcnt", {16'd0, rd_count}, 32'd0);
        chk("rst_wrcnt", {16'd0, wr_count}, 32'd0);
        rst_n = 1'b1;

        // Preload words 16 and 5
        xact("wr40", 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'd0);
        xact("wr14", 1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 32'd0);
        chk("wrcnt_2", {16'd0, wr_count}, 32'd2);

        // Read 0x40 and keep MemRead held afterwards
        @(negedge clk);
        MemRead = 1'b1;
        memAddr = 32'h0000_0040;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (MemReadDone) seen = 1'b1;
        end
        chk("rd40_lat",  32'(lat), 32'd4);
        chk("rd40_rrdy", {31'd0, MemReadReady}, 32'd1);
        chk("rd40_data", memReadData, 32'hDEAD_BEEF);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (MemReadDone) extra++;
        end
        chk("hold_no_repeat", 32'(extra), 32'd0);
        chk("hold_busy",      {31'd0, busy}, 32'd1);
        chk("hold_rdcnt",     {16'd0, rd_count}, 32'd1);
        chk("hold_rdata",     memReadData, 32'hDEAD_BEEF);

        // Move the held read to 0x14: one RELEASE->IDLE cycle plus full latency
        memAddr = 32'h0000_0014;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (MemReadDone) seen = 1'b1;
        end
        chk("rd14_lat",  32'(lat), 32'd5);
        chk("rd14_data", memReadData, 32'hCAFE_F00D);
        MemRead = 1'b0;
        repeat (2) @(negedge clk);
        chk("rd14_idle",  {31'd0, busy}, 32'd0);
        chk("rd14_rdcnt", {16'd0, rd_count}, 32'd2);

        // Write then read back 0x80
        xact("wr80", 1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'd0);
        chk("wr80_wrcnt", {16'd0, wr_count}, 32'd3);
        xact("rd80", 1'b1, 1'b0, 32'h0000_0080, 32'd0, 32'h1234_5678);
        chk("rd80_rdcnt", {16'd0, rd_count}, 32'd3);

        // Simultaneous read and write: write wins
        xact("both10", 1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'd0);
        chk("both_rdcnt", {16'd0, rd_count}, 32'd3);
        chk("both_wrcnt", {16'd0, wr_count}, 32'd4);
        xact("rd10", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 32'hA5A5_A5A5);

        // Aliasing above the index and ignored byte offset
        xact("rd1040", 1'b1, 1'b0, 32'h0000_1040, 32'd0, 32'hDEAD_BEEF);
        xact("rd43",   1'b1, 1'b0, 32'h0000_0043, 32'd0, 32'hDEAD_BEEF);
        chk("alias_rdcnt", {16'd0, rd_count}, 32'd6);

        // Reset in the middle of a write
        xact("wr200", 1'b0, 1'b1, 32'h0000_0200, 32'h1111_1111, 32'd0);
        @(negedge clk);
        MemWrite     = 1'b1;
        memAddr      = 32'h0000_0200;
        memWriteData = 32'h2222_2222;
        @(negedge clk);
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_wrdy",  {31'd0, MemWriteReady}, 32'd0);
        chk("abort_wrcnt", {16'd0, wr_count}, 32'd0);
        chk("abort_rdcnt", {16'd0, rd_count}, 32'd0);
        chk("abort_rdata", memReadData, 32'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (MemWriteReady || busy) extra++;
        end
        chk("abort_quiet", 32'(extra), 32'd0);
        MemWrite = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        xact("rd200", 1'b1, 1'b0, 32'h0000_0200, 32'd0, 32'h1111_1111);
        chk("post_rdcnt", {16'd0, rd_count}, 32'd1);
        chk("post_wrcnt", {16'd0, wr_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
- Backing-memory controller directly downstream of the direct-mapped data cache; services every cache read fill and every write-through.
- Drives the cache's memory-side handshake inputs (MemReadReady, MemReadDone, memReadData, MemWriteReady) from the same MemRead/MemWrite/memAddr the cache sees.
- Word-addressed storage with configurable fixed read/write latency, so the cache and CPU can be exercised against realistic miss penalties.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two.
- READ_LATENCY, 4: cycles from the read-accept edge to data valid; must be ≥1.
- WRITE_LATENCY, 4: cycles from the write-accept edge to commit; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  read request, level.
- MemWrite  in  1  write request, level.
- memAddr  in  32  byte address; word index = memAddr[log2(DEPTH_WORDS)+1:2].
- memWriteData  in  32  write data.
- memReadData  out  32  read data; valid while MemReadDone=1.
- MemReadReady  out  1  one-cycle pulse: fill data valid, cache may latch.
- MemReadDone  out  1  one-cycle pulse coincident with MemReadReady.
- MemWriteReady  out  1  one-cycle pulse: write committed.
- busy  out  1  high in any state other than IDLE.
- rd_count  out  16  completed reads, wraps at 0xFFFF→0.
- wr_count  out  16  completed writes, wraps.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, memReadData=0, latency counter=0, latched addr/data=0, counters=0. Storage array is not reset (simulation init = all zero).
- States: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE, RELEASE.
- IDLE:
  - If MemWrite=1, latch word index and memWriteData, load counter=WRITE_LATENCY-1, go WR_WAIT (or WR_DONE if WRITE_LATENCY=1).
  - Else if MemRead=1, latch word index, load counter=READ_LATENCY-1, go RD_WAIT (or RD_DONE if READ_LATENCY=1).
  - Simultaneous read and write: write wins; the read is not serviced.
- RD_WAIT / WR_WAIT: decrement counter each cycle; at 0 go RD_DONE / WR_DONE. Input changes during the wait are ignored because address and data are latched.
- RD_DONE: one cycle. MemReadReady=MemReadDone=1, memReadData=mem[latched index], rd_count+1. Next state is RELEASE.
- WR_DONE: one cycle. mem[latched index]<=latched data on the closing edge, MemWriteReady=1, wr_count+1. Next state is RELEASE.
- Latency: request sampled at accepting edge E; the DONE-state pulse is high in the cycle following edge E+READ_LATENCY-1 (resp. WRITE_LATENCY-1). Total = READ_LATENCY cycles.
- RELEASE: prevents re-servicing a request that is still held.
  - Go to IDLE when (MemRead=0 and MemWrite=0) or the memAddr word index differs from the latched index.
  - The transition costs one cycle; no accept happens in RELEASE.
- memReadData holds its last value outside RD_DONE. Consumers must qualify it with MemReadDone.
- Address bits above the index wrap (modulo DEPTH_WORDS). memAddr[1:0] are ignored.
- Counters wrap silently.
- Reset asserted mid-transaction: the transaction is abandoned, no pulse is produced, and a write not yet in WR_DONE does not commit.

Decomposition:
- Package main_mem_pkg:
  - state enum (typedef mem_state_t).
  - WORD_W=32.
  - function for index width (clog2 of DEPTH_WORDS).
- Sub-module main_mem_array: single-port storage, synchronous write with enable, combinational read on index.
- Controller FSM, latency counter and stats counters live in main_mem_ctrl.

Test Plan:
- Reset then MemRead=1, memAddr=0x40 (mem[16] preloaded 0xDEADBEEF), READ_LATENCY=4 → MemReadDone/MemReadReady high for exactly 1 cycle, 4 cycles after the accept edge, memReadData=0xDEADBEEF, rd_count=1.
- MemWrite=1, memAddr=0x80, memWriteData=0x12345678, then read 0x80 → MemWriteReady pulses after 4 cycles; the later read returns 0x12345678; wr_count=1.
- MemRead and MemWrite both 1 at 0x10 with data 0xA5A5A5A5 → only MemWriteReady pulses, rd_count unchanged, mem[4]=0xA5A5A5A5.
- MemRead held high at same address after done → no second MemReadDone. Changing memAddr to 0x14 → a new read starts 1 cycle later (RELEASE→IDLE) and completes after READ_LATENCY.
- memAddr=0x1000+0x40 with DEPTH_WORDS=1024 → aliases mem[16]. memAddr=0x43 reads the same word as 0x40.
- rst_n dropped during WR_WAIT (cycle 2 of 4) → outputs 0 immediately, no MemWriteReady, target word unchanged, state IDLE after release.
